// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker: self-synchronising PRBS7/PRBS15/toggle lane checker with lock FSM and saturating counters; optional first-error capture under PRBS_RX_FIRST_ERR_EN
module prbs_rx_checker #(
   parameter int RECV_W     = 58,
   parameter int ERR_W      = 64,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   input  logic [1:0]        PATTERN,
   input  logic [1:0]        DIN,
   output logic              PHY_INIT,
   output logic [RECV_W-1:0] RECV_CNT,
`ifdef PRBS_RX_FIRST_ERR_EN
   output logic [ERR_W-1:0]  ERR_CNT,
   output logic [RECV_W-1:0] FIRST_ERR_POS,
   output logic              FIRST_ERR_VLD
`else
   output logic [ERR_W-1:0]  ERR_CNT
`endif
);
   localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [1:0]         pat_q;
   logic               pat_chg, chk_off, restart;
   logic [14:0]        hist;
   logic               exp1, exp0, err1, err0;
   logic [1:0]         m;
   logic [3:0]         fill, fill_nxt, fill_len;
   logic [CLEAN_W-1:0] clean, clean_nxt;
   logic [BAD_W-1:0]   bad, bad_nxt;
   logic               phy_nxt, cnt_en;
   logic [RECV_W:0]    recv_sum;
   logic [ERR_W:0]     err_sum;

   // A mode switch is detected against last cycle's PATTERN; loading during reset avoids a false switch afterwards
   always_ff @(posedge CLK) begin
      pat_q <= PATTERN;
   end

   assign pat_chg  = PATTERN != pat_q;
   assign chk_off  = PATTERN == 2'b11;
   assign restart  = pat_chg || chk_off;
   assign fill_len = PATTERN[1] ? 4'd1 : PATTERN[0] ? 4'd8 : 4'd4;

   // DIN[1] is predicted from hist; DIN[0] is predicted from hist with DIN[1] already shifted in
   assign exp1 = PATTERN[0] ? hist[14] ^ hist[13] : hist[6] ^ hist[5];
   assign exp0 = PATTERN[0] ? hist[13] ^ hist[12] : hist[5] ^ hist[4];
   assign err1 = PATTERN[1] ? ~DIN[1] : DIN[1] ^ exp1;
   assign err0 = PATTERN[1] ? DIN[0] : DIN[0] ^ exp0;
   assign m    = {1'b0, err1} + {1'b0, err0};

   // History always takes the received bits so the checker re-seeds itself from the line
   always_ff @(posedge CLK) begin
      if (RST || restart)
         hist <= '0;
      else
         hist <= {hist[12:0], DIN};
   end

   // FSM state register, its counters and the registered lock flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= HUNT;
         fill     <= '0;
         clean    <= '0;
         bad      <= '0;
         PHY_INIT <= 1'b0;
      end else begin
         state    <= state_nxt;
         fill     <= fill_nxt;
         clean    <= clean_nxt;
         bad      <= bad_nxt;
         PHY_INIT <= phy_nxt;
      end
   end

   // Next state: fill the history, qualify LOCK_CNT clean cycles, drop after UNLOCK_CNT errored cycles
   always_comb begin
      state_nxt = state;
      fill_nxt  = fill;
      clean_nxt = clean;
      bad_nxt   = bad;
      if (restart) begin
         state_nxt = HUNT;
         fill_nxt  = '0;
         clean_nxt = '0;
         bad_nxt   = '0;
      end else begin
         case (state)
            HUNT: begin
               fill_nxt = fill + 4'd1;
               if (fill_nxt >= fill_len) begin
                  state_nxt = SYNC;
                  clean_nxt = '0;
               end
            end
            SYNC: begin
               clean_nxt = (m == 2'd0) ? clean + 1'b1 : '0;
               if (clean_nxt == CLEAN_W'(LOCK_CNT)) begin
                  state_nxt = LOCKED;
                  bad_nxt   = '0;
               end
            end
            LOCKED: begin
               bad_nxt = (m != 2'd0) ? bad + 1'b1 : '0;
               if (bad_nxt == BAD_W'(UNLOCK_CNT)) begin
                  state_nxt = HUNT;
                  fill_nxt  = '0;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // Outputs: lock flag lags the state by a cycle except on a mode switch, counting follows the current state
   always_comb begin
      phy_nxt = state == LOCKED && !restart;
      cnt_en  = state == LOCKED && !pat_chg;
   end

   assign recv_sum = {1'b0, RECV_CNT} + (RECV_W + 1)'(2);
   assign err_sum  = {1'b0, ERR_CNT} + (ERR_W + 1)'(m);

   // Saturating bit and error counters; CLR overrides the increment of its own cycle
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         RECV_CNT <= '0;
         ERR_CNT  <= '0;
      end else if (cnt_en) begin
         RECV_CNT <= recv_sum[RECV_W] ? '1 : recv_sum[RECV_W-1:0];
         ERR_CNT  <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      end
   end

`ifdef PRBS_RX_FIRST_ERR_EN
   // Capture the bit position of the first counted error since reset or clear
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         FIRST_ERR_POS <= '0;
         FIRST_ERR_VLD <= 1'b0;
      end else if (cnt_en && m != 2'd0 && !FIRST_ERR_VLD) begin
         FIRST_ERR_POS <= RECV_CNT;
         FIRST_ERR_VLD <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb_prbs_rx_checker: lock timing, error counting, unlock, clear, mode switch, off mode, saturation and reset checks
module tb_prbs_rx_checker;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CLR = 1'b0;
   logic [1:0]  PATTERN = 2'b00;
   logic [1:0]  DIN = 2'b00;
   logic        PHY_INIT, sat_phy;
   logic [57:0] RECV_CNT, sat_recv;
   logic [63:0] ERR_CNT;
   logic [3:0]  sat_err;
`ifdef PRBS_RX_FIRST_ERR_EN
   logic [57:0] FIRST_ERR_POS, sat_pos;
   logic        FIRST_ERR_VLD, sat_vld;
`endif

   typedef struct {logic [1:0] din; int m;} vec_t;
   typedef struct {longint recv; longint err; int sat;} exp_t;

   int          checks = 0;
   int          failures = 0;
   logic [14:0] gen = 15'h7fff;
   logic [14:0] hist = '0;
   longint      erec, eerr;
   int          esat;
   exp_t        sbq[$];
   vec_t        tbl[8];

   always #5 CLK = ~CLK;

   prbs_rx_checker u_dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .PATTERN(PATTERN), .DIN(DIN),
      .PHY_INIT(PHY_INIT), .RECV_CNT(RECV_CNT),
`ifdef PRBS_RX_FIRST_ERR_EN
      .FIRST_ERR_POS(FIRST_ERR_POS), .FIRST_ERR_VLD(FIRST_ERR_VLD),
`endif
      .ERR_CNT(ERR_CNT)
   );

   prbs_rx_checker #(.ERR_W(4)) u_sat (
      .CLK(CLK), .RST(RST), .CLR(CLR), .PATTERN(PATTERN), .DIN(DIN),
      .PHY_INIT(sat_phy), .RECV_CNT(sat_recv),
`ifdef PRBS_RX_FIRST_ERR_EN
      .FIRST_ERR_POS(sat_pos), .FIRST_ERR_VLD(sat_vld),
`endif
      .ERR_CNT(sat_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic tap(input logic [14:0] h, input logic p15);
      return p15 ? h[14] ^ h[13] : h[6] ^ h[5];
   endfunction

   // One cycle of line data: clean, with DIN[1] flipped, or the inverse of what the checker predicts
   task automatic send(input logic flip, input logic inv);
      logic b1, b0;
      if (PATTERN[1]) begin
         DIN = 2'b10;
      end else begin
         b1 = tap(gen, PATTERN[0]);
         gen = {gen[13:0], b1};
         b0 = tap(gen, PATTERN[0]);
         gen = {gen[13:0], b0};
         if (inv) begin
            b1 = ~tap(hist, PATTERN[0]);
            hist = {hist[13:0], b1};
            b0 = ~tap(hist, PATTERN[0]);
            hist = {hist[13:0], b0};
         end else begin
            b1 = b1 ^ flip;
            hist = {hist[12:0], b1, b0};
         end
         DIN = {b1, b0};
      end
      tick;
   endtask

   // Scoreboarded locked-cycle step: expectation queued with the stimulus, compared when the outputs update
   task automatic sb_step(input logic [1:0] d, input int mm);
      exp_t e;
      DIN = d;
      erec += 2;
      eerr += mm;
      esat = (esat + mm > 15) ? 15 : esat + mm;
      e.recv = erec;
      e.err = eerr;
      e.sat = esat;
      sbq.push_back(e);
      tick;
      e = sbq.pop_front();
      chk("sb_recv", RECV_CNT, e.recv);
      chk("sb_err", ERR_CNT, e.err);
      chk("sb_sat_err", 64'(sat_err), 64'(e.sat));
      chk("sb_sat_recv", sat_recv, e.recv);
      chk("sb_phy", PHY_INIT, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{2'b10, 0};
      tbl[1] = '{2'b11, 1};
      tbl[2] = '{2'b10, 0};
      tbl[3] = '{2'b00, 1};
      tbl[4] = '{2'b10, 0};
      tbl[5] = '{2'b01, 2};
      tbl[6] = '{2'b11, 1};
      tbl[7] = '{2'b10, 0};

      repeat (3) tick;
      chk("rst_phy", PHY_INIT, 0);
      chk("rst_recv", RECV_CNT, 0);
      chk("rst_err", ERR_CNT, 0);
      chk("rst_sat_err", 64'(sat_err), 0);
`ifdef PRBS_RX_FIRST_ERR_EN
      chk("rst_vld", FIRST_ERR_VLD, 0);
`endif

      RST = 1'b0;
      for (int i = 1; i <= 20; i++) send(1'b0, 1'b0);
      chk("lock7_phy_c20", PHY_INIT, 0);
      chk("lock7_recv_c20", RECV_CNT, 0);
      send(1'b0, 1'b0);
      chk("lock7_phy_c21", PHY_INIT, 1);
      chk("lock7_recv_c21", RECV_CNT, 2);
      for (int i = 0; i < 99; i++) send(1'b0, 1'b0);
      chk("lock7_recv_200", RECV_CNT, 200);
      chk("lock7_err_0", ERR_CNT, 0);

      CLR = 1'b1;
      send(1'b0, 1'b0);
      CLR = 1'b0;
      chk("clr_recv", RECV_CNT, 0);
      chk("clr_err", ERR_CNT, 0);
      chk("clr_phy", PHY_INIT, 1);
      send(1'b0, 1'b0);
      chk("clr_recv_next", RECV_CNT, 2);

      for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
      chk("unlock_phy_held", PHY_INIT, 1);
      chk("unlock_err_3", ERR_CNT, 6);
      send(1'b0, 1'b1);
      chk("unlock_err", ERR_CNT, 8);
      chk("unlock_recv", RECV_CNT, 10);
      send(1'b0, 1'b0);
      chk("unlock_phy", PHY_INIT, 0);
      chk("unlock_recv_hold", RECV_CNT, 10);

      PATTERN = 2'b10;
      send(1'b0, 1'b0);
      chk("switch_phy", PHY_INIT, 0);
      for (int i = 0; i < 17; i++) send(1'b0, 1'b0);
      chk("toggle_phy_c17", PHY_INIT, 0);
      chk("toggle_recv_c17", RECV_CNT, 10);
      send(1'b0, 1'b0);
      chk("toggle_phy_c18", PHY_INIT, 1);
      chk("toggle_recv_c18", RECV_CNT, 12);
      chk("toggle_err_c18", ERR_CNT, 8);
      chk("toggle_sat_c18", 64'(sat_err), 8);

      erec = 12;
      eerr = 8;
      esat = 8;
      foreach (tbl[i]) sb_step(tbl[i].din, tbl[i].m);

      DIN = 2'b10;
      CLR = 1'b1;
      tick;
      CLR = 1'b0;
      chk("sat_clr_err", 64'(sat_err), 0);
      chk("sat_clr_recv", RECV_CNT, 0);
      erec = 0;
      eerr = 0;
      esat = 0;
      for (int k = 0; k < 10; k++) begin
         sb_step(2'b01, 2);
         sb_step(2'b10, 0);
      end
      chk("sat_final", 64'(sat_err), 15);
      chk("nosat_final", ERR_CNT, 20);

      PATTERN = 2'b11;
      DIN = 2'b00;
      tick;
      chk("off_phy", PHY_INIT, 0);
      chk("off_recv_hold", RECV_CNT, 40);
      for (int i = 0; i < 5; i++) begin
         DIN = 2'($urandom_range(0, 3));
         tick;
      end
      chk("off_phy_later", PHY_INIT, 0);
      chk("off_recv_frozen", RECV_CNT, 40);
      chk("off_err_frozen", ERR_CNT, 20);
      CLR = 1'b1;
      tick;
      CLR = 1'b0;
      chk("off_clr_recv", RECV_CNT, 0);
      chk("off_clr_err", ERR_CNT, 0);

      PATTERN = 2'b01;
      n = 0;
      do begin
         send(1'b0, 1'b0);
         n++;
      end while (!PHY_INIT && n < 40);
      chk("lock15_cycles", 64'(n), 26);
      chk("lock15_recv", RECV_CNT, 2);
      chk("lock15_err", ERR_CNT, 0);

      send(1'b1, 1'b0);
      chk("flip_direct", ERR_CNT, 1);
      for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
      chk("flip_c7", ERR_CNT, 1);
      send(1'b0, 1'b0);
      chk("flip_c8", ERR_CNT, 3);
      chk("flip_recv", RECV_CNT, 18);
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
      chk("flip_settled", ERR_CNT, 3);
      chk("flip_phy", PHY_INIT, 1);

`ifdef PRBS_RX_FIRST_ERR_EN
      CLR = 1'b1;
      send(1'b0, 1'b0);
      CLR = 1'b0;
      chk("fe_clr_vld", FIRST_ERR_VLD, 0);
      chk("fe_clr_pos", FIRST_ERR_POS, 0);
      for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
      chk("fe_recv_20", RECV_CNT, 20);
      chk("fe_vld_clean", FIRST_ERR_VLD, 0);
      send(1'b1, 1'b0);
      chk("fe_vld", FIRST_ERR_VLD, 1);
      chk("fe_pos", FIRST_ERR_POS, 20);
      for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
      chk("fe_pos_hold", FIRST_ERR_POS, 20);
      chk("fe_err_total", ERR_CNT, 6);
`endif

      RST = 1'b1;
      send(1'b0, 1'b0);
      chk("midrst_phy", PHY_INIT, 0);
      chk("midrst_recv", RECV_CNT, 0);
      chk("midrst_err", ERR_CNT, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
